// File: rtl/recorder_pkg.sv
// recorder_pkg: shared state encoding and default parameters for the
// recorder control block.
package recorder_pkg;

    // State encoding is visible on the `state` output, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2,
        ST_ERASE  = 2'd3
    } rec_state_t;

    localparam int DEF_ADDR_BITS   = 16;
    localparam int DEF_LONG_CYCLES = 37500000;  // 1 s at 37.5 MHz
    localparam int DEF_CNT_BITS    = 26;

endpackage

// File: rtl/recorder_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for one debounced button level.
//   clk, reset_n : clock, async active-low reset
//   lvl          : debounced level, 1 = pressed
//   press        : one-cycle pulse in the cycle the level rises
// The previous-level register resets to 1 so a button held through reset
// gives no press until it has been released once.
module btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic lvl,
    output logic press
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = lvl;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b1;
        else          prev_q <= prev_d;
    end

    assign press = lvl & ~prev_q;

endmodule

// File: rtl/recorder_ctrl.sv
// recorder_ctrl: record / playback / erase control for the audio recorder.
//   clk, reset_n        : single clock, async active-low reset
//   btn_rec, btn_play   : debounced button levels, 1 = pressed
//   sample_tick         : one-cycle pulse per codec sample
//   mem_we, mem_addr    : sample-memory write enable and address
//   play_en             : high while in PLAY
//   rec_len             : number of valid recorded samples (0..2^ADDR_BITS)
//   state               : IDLE=0, RECORD=1, PLAY=2, ERASE=3
module recorder_ctrl
    import recorder_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int CNT_BITS    = DEF_CNT_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_rec,
    input  logic                 btn_play,
    input  logic                 sample_tick,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 play_en,
    output logic [ADDR_BITS:0]   rec_len,
    output logic [1:0]           state
);

    localparam logic [CNT_BITS-1:0]  HOLD_LAST = CNT_BITS'(LONG_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_BITS:0]   LEN_ONE   = (ADDR_BITS+1)'(1);

    logic rec_press, play_press;

    btn_edge u_edge_rec (
        .clk     (clk),
        .reset_n (reset_n),
        .lvl     (btn_rec),
        .press   (rec_press)
    );

    btn_edge u_edge_play (
        .clk     (clk),
        .reset_n (reset_n),
        .lvl     (btn_play),
        .press   (play_press)
    );

    rec_state_t            state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS:0]    rec_len_q, rec_len_d;
    logic [CNT_BITS-1:0]   hold_cnt_q, hold_cnt_d;
    logic                  erase_armed_q, erase_armed_d;

    logic both_hi, both_lo;
    assign both_hi = btn_rec & btn_play;
    assign both_lo = ~btn_rec & ~btn_play;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rec_len_d     = rec_len_q;
        hold_cnt_d    = '0;
        erase_armed_d = erase_armed_q;

        // Re-arm only once both buttons are released: one hold, one erase.
        if (both_lo) erase_armed_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // Saturate so a long hold after an erase cannot wrap.
                if (both_hi)
                    hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                           : hold_cnt_q + 1'b1;
                if (erase_armed_q && hold_cnt_q == HOLD_LAST) begin
                    state_d       = ST_ERASE;
                    erase_armed_d = 1'b0;
                end else if (rec_press && !play_press) begin
                    state_d = ST_RECORD;
                    addr_d  = '0;
                end else if (play_press && !rec_press && rec_len_q != '0) begin
                    state_d = ST_PLAY;
                    addr_d  = '0;
                end
            end

            ST_RECORD: begin
                if (sample_tick) addr_d = addr_q + 1'b1;
                // A tick in the stop cycle is still written and counted.
                if (rec_press || (sample_tick && addr_q == ADDR_LAST)) begin
                    state_d   = ST_IDLE;
                    rec_len_d = {1'b0, addr_q} + {{ADDR_BITS{1'b0}}, sample_tick};
                end
            end

            ST_PLAY: begin
                if (sample_tick) addr_d = addr_q + 1'b1;
                if (play_press)
                    state_d = ST_IDLE;
                else if (sample_tick && {1'b0, addr_q} == rec_len_q - LEN_ONE)
                    state_d = ST_IDLE;
            end

            ST_ERASE: begin
                rec_len_d = '0;
                addr_d    = '0;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            rec_len_q     <= '0;
            hold_cnt_q    <= '0;
            erase_armed_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rec_len_q     <= rec_len_d;
            hold_cnt_q    <= hold_cnt_d;
            erase_armed_q <= erase_armed_d;
        end
    end

    // Write enable follows the tick with no latency while recording.
    assign mem_we   = (state_q == ST_RECORD) & sample_tick;
    assign mem_addr = addr_q;
    assign play_en  = (state_q == ST_PLAY);
    assign rec_len  = rec_len_q;
    assign state    = state_q;

endmodule
